// File: rtl/fma_pkg.sv
// Shared types and the saturate/wrap helper for the fixed-point FMA array.
package fma_pkg;

   localparam int SUM_MAX = 64;

   typedef struct packed {
      logic acc_sel;
      logic emit;
   } fma_ctrl_t;

   typedef struct packed {
      logic signed [SUM_MAX-1:0] value;
      logic                      ovf;
   } sat_res_t;

   // value keeps the full sum when wrapping; the caller takes the low width bits
   function automatic sat_res_t sat_trunc(input logic signed [SUM_MAX-1:0] sum,
                                          input int width, input bit saturate);
      sat_res_t r;
      logic signed [SUM_MAX-1:0] hi;
      logic signed [SUM_MAX-1:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      r.ovf = (sum > hi) || (sum < lo);
      r.value = sum;
      if (saturate && (sum > hi)) r.value = hi;
      else if (saturate && (sum < lo)) r.value = lo;
      return r;
   endfunction

endpackage

// File: rtl/fma_lane.sv
// One FMA lane: product register, round/shift/add/saturate, and the result
// register that doubles as the lane accumulator.
module fma_lane
   import fma_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int FIXED_POINT = 10,
   parameter int SATURATE    = 1,
   parameter int ROUND       = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic                    update,
   input  logic                    acc_sel,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   input  logic signed [WIDTH-1:0] c,
   output logic signed [WIDTH-1:0] result,
   output logic                    ovf
);

   localparam int PW = 2 * WIDTH;
   localparam int SW = PW + 1;

   logic signed [PW-1:0]    prod_p1;
   logic signed [WIDTH-1:0] c_p1;
   logic signed [SW-1:0]    addend_p2;
   logic        [WIDTH:0]   next_p2;

   function automatic logic signed [SW-1:0] round_shift(input logic signed [PW-1:0] p);
      logic signed [SW-1:0] t;
      logic signed [SW-1:0] half;
      half = '0;
      if (ROUND != 0) half[FIXED_POINT-1] = 1'b1;
      t = {p[PW-1], p} + half;
      return t >>> FIXED_POINT;
   endfunction

   function automatic logic [WIDTH:0] sat_word(input logic signed [SW-1:0] s);
      sat_res_t r;
      r = sat_trunc(SUM_MAX'(s), WIDTH, SATURATE != 0);
      return {r.ovf, r.value[WIDTH-1:0]};
   endfunction

   // Stage 1: full-precision product and addend capture
   always_ff @(posedge clk) begin
      if (load) begin
         prod_p1 <= PW'(a) * PW'(b);
         c_p1    <= c;
      end
   end

   // Stage 2: the accumulator is read straight from the result register
   assign addend_p2 = acc_sel ? SW'(result) : SW'(c_p1);
   assign next_p2   = sat_word(round_shift(prod_p1) + addend_p2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
         ovf    <= 1'b0;
      end else if (update) begin
         result <= next_p2[WIDTH-1:0];
         ovf    <= next_p2[WIDTH];
      end
   end

endmodule

// File: rtl/fma_array.sv
// LANES-wide two-stage fixed-point fused multiply-add with accumulate, sharing
// one valid/ready handshake on each side.
module fma_array
   import fma_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int FIXED_POINT = 10,
   parameter int LANES       = 4,
   parameter int SATURATE    = 1,
   parameter int ROUND       = 1
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*WIDTH-1:0] a_in,
   input  logic [LANES*WIDTH-1:0] b_in,
   input  logic [LANES*WIDTH-1:0] c_in,
   input  logic                   acc_sel_in,
   input  logic                   emit_in,
   output logic [LANES*WIDTH-1:0] out_data,
   output logic [LANES-1:0]       out_ovf,
   output logic                   out_valid,
   input  logic                   out_ready
);

   logic      advance;
   logic      accept;
   logic      vld_p1;
   fma_ctrl_t ctrl_in;
   fma_ctrl_t ctrl_p1;

   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;
   assign accept   = in_valid & advance;
   assign ctrl_in  = '{acc_sel: acc_sel_in, emit: emit_in};

   // Stage 1 control; out_valid acts as the stage 2 valid
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         vld_p1    <= 1'b0;
         out_valid <= 1'b0;
      end else if (advance) begin
         vld_p1    <= in_valid;
         out_valid <= vld_p1 & ctrl_p1.emit;
      end
   end

   always_ff @(posedge clk_in) begin
      if (accept) ctrl_p1 <= ctrl_in;
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      fma_lane #(
         .WIDTH      (WIDTH),
         .FIXED_POINT(FIXED_POINT),
         .SATURATE   (SATURATE),
         .ROUND      (ROUND)
      ) u_lane (
         .clk    (clk_in),
         .rst    (rst_in),
         .load   (accept),
         .update (advance & vld_p1),
         .acc_sel(ctrl_p1.acc_sel),
         .a      (a_in[i*WIDTH +: WIDTH]),
         .b      (b_in[i*WIDTH +: WIDTH]),
         .c      (c_in[i*WIDTH +: WIDTH]),
         .result (out_data[i*WIDTH +: WIDTH]),
         .ovf    (out_ovf[i])
      );
   end

endmodule

// File: tb/tb_fma_array.sv
// Bench for fma_array: saturating/rounding and wrapping/truncating instances
// driven in lockstep and compared against an arithmetic reference model.
module tb_fma_array;

   localparam int W = 16;
   localparam int F = 10;
   localparam int L = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic           in_ready_w;
   logic [L*W-1:0] a;
   logic [L*W-1:0] b;
   logic [L*W-1:0] c;
   logic           acc_sel;
   logic           emit;
   logic [L*W-1:0] out_data;
   logic [L*W-1:0] out_data_w;
   logic [L-1:0]   out_ovf;
   logic [L-1:0]   out_ovf_w;
   logic           out_valid;
   logic           out_valid_w;
   logic           out_ready;

   int vectors = 0;
   int miscompares = 0;
   int pulses = 0;

   typedef struct {
      logic [L*W-1:0] data;
      logic [L-1:0]   ovf;
   } res_t;

   res_t   q_s[$];
   res_t   q_w[$];
   longint acc_s[L];
   longint acc_w[L];

   logic [L*W-1:0] last_data;
   logic [L-1:0]   last_ovf;
   logic [L*W-1:0] last_data_w;
   logic [L-1:0]   last_ovf_w;
   logic           smp_in_ready;
   logic [L*W-1:0] smp_data;

   fma_array #(.WIDTH(W), .FIXED_POINT(F), .LANES(L), .SATURATE(1), .ROUND(1)) dut (
      .clk_in(clk), .rst_in(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a), .b_in(b), .c_in(c), .acc_sel_in(acc_sel), .emit_in(emit),
      .out_data(out_data), .out_ovf(out_ovf), .out_valid(out_valid), .out_ready(out_ready)
   );

   fma_array #(.WIDTH(W), .FIXED_POINT(F), .LANES(L), .SATURATE(0), .ROUND(0)) dut_w (
      .clk_in(clk), .rst_in(rst), .in_valid(in_valid), .in_ready(in_ready_w),
      .a_in(a), .b_in(b), .c_in(c), .acc_sel_in(acc_sel), .emit_in(emit),
      .out_data(out_data_w), .out_ovf(out_ovf_w), .out_valid(out_valid_w), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Reference arithmetic for one lane, in plain integers
   function automatic void ref_lane(input longint av, input longint bv, input longint cv,
                                    input longint prev, input bit acc, input bit sat,
                                    input bit rnd, output longint val, output bit ovf);
      longint p, s, hi, lo;
      hi = (longint'(1) << (W - 1)) - 1;
      lo = -(longint'(1) << (W - 1));
      p = av * bv;
      if (rnd) p = p + (longint'(1) << (F - 1));
      p = p >>> F;
      s = p + (acc ? prev : cv);
      ovf = (s > hi) || (s < lo);
      if (sat) val = (s > hi) ? hi : ((s < lo) ? lo : s);
      else begin
         val = s & 64'hFFFF;
         if (val > hi) val = val - (longint'(1) << W);
      end
   endfunction

   task automatic model_accept();
      res_t   rs, rw;
      longint av, bv, cv, v;
      bit     o;
      for (int l = 0; l < L; l++) begin
         av = longint'($signed(a[l*W +: W]));
         bv = longint'($signed(b[l*W +: W]));
         cv = longint'($signed(c[l*W +: W]));
         ref_lane(av, bv, cv, acc_s[l], acc_sel, 1'b1, 1'b1, v, o);
         acc_s[l] = v;
         rs.data[l*W +: W] = v[W-1:0];
         rs.ovf[l] = o;
         ref_lane(av, bv, cv, acc_w[l], acc_sel, 1'b0, 1'b0, v, o);
         acc_w[l] = v;
         rw.data[l*W +: W] = v[W-1:0];
         rw.ovf[l] = o;
      end
      if (emit) begin
         q_s.push_back(rs);
         q_w.push_back(rw);
      end
   endtask

   task automatic model_reset();
      q_s.delete();
      q_w.delete();
      for (int l = 0; l < L; l++) begin
         acc_s[l] = 0;
         acc_w[l] = 0;
      end
   endtask

   task automatic check_out();
      res_t e;
      if (out_valid && out_ready) begin
         pulses++;
         last_data = out_data;
         last_ovf  = out_ovf;
         if (q_s.size() == 0) chk("spurious_valid_sat", {63'b0, out_valid}, 64'd0);
         else begin
            e = q_s.pop_front();
            chk("data_sat", out_data, e.data);
            chk("ovf_sat", {60'b0, out_ovf}, {60'b0, e.ovf});
         end
      end
      if (out_valid_w && out_ready) begin
         last_data_w = out_data_w;
         last_ovf_w  = out_ovf_w;
         if (q_w.size() == 0) chk("spurious_valid_wrap", {63'b0, out_valid_w}, 64'd0);
         else begin
            e = q_w.pop_front();
            chk("data_wrap", out_data_w, e.data);
            chk("ovf_wrap", {60'b0, out_ovf_w}, {60'b0, e.ovf});
         end
      end
   endtask

   // One clock: drive at posedge+1, sample and score at negedge
   task automatic step(input logic [L*W-1:0] ta, input logic [L*W-1:0] tb,
                       input logic [L*W-1:0] tc, input bit ts, input bit te,
                       input bit tv, input bit tr, output bit accepted);
      a = ta; b = tb; c = tc; acc_sel = ts; emit = te;
      in_valid = tv; out_ready = tr;
      @(negedge clk);
      smp_in_ready = in_ready;
      smp_data = out_data;
      check_out();
      accepted = tv && in_ready;
      if (accepted) model_accept();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input bit tr);
      bit acc;
      step('0, '0, '0, 1'b0, 1'b0, 1'b0, tr, acc);
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 20 && (q_s.size() > 0 || q_w.size() > 0); k++) idle(1'b1);
      chk({tag, "_drained_sat"}, 64'(q_s.size()), 64'd0);
      chk({tag, "_drained_wrap"}, 64'(q_w.size()), 64'd0);
   endtask

   function automatic logic [L*W-1:0] rnd_word();
      logic [L*W-1:0] w;
      for (int l = 0; l < L; l++)
         w[l*W +: W] = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                   : 16'($urandom_range(0, 8191) - 4096);
      return w;
   endfunction

   initial begin
      bit             acc;
      int             idx;
      bit             r;
      logic [L*W-1:0] prev;
      logic [L*W-1:0] bp_a[6];
      logic [L*W-1:0] bp_b[6];
      logic [L*W-1:0] bp_c[6];
      bit             bp_s[6];

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c = '0;
      acc_sel = 1'b0; emit = 1'b0; out_ready = 1'b1;
      model_reset();
      #12;
      chk("rst_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_data", out_data, 64'd0);
      chk("rst_ovf", {60'b0, out_ovf}, 64'd0);
      chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic FMA and two-cycle latency
      step({4{16'h0600}}, {4{16'h0800}}, {4{16'h0100}}, 1'b0, 1'b1, 1'b1, 1'b1, acc);
      chk("t1_accept", {63'b0, acc}, 64'd1);
      chk("t1_lat1", {63'b0, out_valid}, 64'd0);
      idle(1'b1);
      chk("t1_valid", {63'b0, out_valid}, 64'd1);
      chk("t1_data", out_data, {4{16'h0D00}});
      chk("t1_ovf", {60'b0, out_ovf}, 64'd0);
      drain("t1");

      // Saturation and wrap on overflow
      step({16'h0, 16'h0, 16'hC000, 16'h4000}, {16'h0, 16'h0, 16'h4000, 16'h4000},
           '0, 1'b0, 1'b1, 1'b1, 1'b1, acc);
      drain("t2");
      chk("t2_sat_data", last_data, {16'h0000, 16'h0000, 16'h8000, 16'h7FFF});
      chk("t2_sat_ovf", {60'b0, last_ovf}, 64'h3);
      chk("t2_wrap_data", last_data_w, 64'd0);
      chk("t2_wrap_ovf", {60'b0, last_ovf_w}, 64'h3);

      // Rounding half-up against truncation
      step({4{16'h0001}}, {4{16'h0200}}, '0, 1'b0, 1'b1, 1'b1, 1'b1, acc);
      drain("t3");
      chk("t3_round", last_data, {4{16'h0001}});
      chk("t3_trunc", last_data_w, 64'd0);

      // Accumulate chain, single emitted result
      pulses = 0;
      for (int k = 0; k < 4; k++)
         step({4{16'h0400}}, {4{16'h0400}}, '0, k != 0, k == 3, 1'b1, 1'b1, acc);
      drain("t4");
      chk("t4_pulses", 64'(pulses), 64'd1);
      chk("t4_data", last_data, {4{16'h1000}});

      // Backpressure mid-stream
      for (int i = 0; i < 6; i++) begin
         bp_a[i] = rnd_word(); bp_b[i] = rnd_word(); bp_c[i] = rnd_word();
         bp_s[i] = (i != 0) && ($urandom_range(0, 1) == 1);
      end
      idx = 0;
      prev = out_data;
      for (int k = 0; k < 40 && (idx < 6 || q_s.size() > 0); k++) begin
         r = !(k >= 3 && k < 6);
         if (idx < 6) step(bp_a[idx], bp_b[idx], bp_c[idx], bp_s[idx], 1'b1, 1'b1, r, acc);
         else step('0, '0, '0, 1'b0, 1'b0, 1'b0, r, acc);
         if (acc) idx++;
         if (!r) begin
            chk("t5_in_ready", {63'b0, smp_in_ready}, 64'd0);
            if (k > 3) chk("t5_stable", smp_data, prev);
         end
         prev = smp_data;
      end
      chk("t5_count", 64'(idx), 64'd6);
      drain("t5");

      // Randomized traffic with random backpressure
      for (int k = 0; k < 300; k++)
         step(rnd_word(), rnd_word(), rnd_word(), $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 4) != 0, acc);
      drain("rand");

      // Reset with both stages occupied
      step({4{16'h0600}}, {4{16'h0800}}, {4{16'h0100}}, 1'b0, 1'b1, 1'b1, 1'b1, acc);
      step({4{16'h0400}}, {4{16'h0400}}, {4{16'h0100}}, 1'b0, 1'b1, 1'b1, 1'b1, acc);
      chk("t6_pre_valid", {63'b0, out_valid}, 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_valid", {63'b0, out_valid}, 64'd0);
      chk("t6_rst_data", out_data, 64'd0);
      chk("t6_rst_ovf", {60'b0, out_ovf}, 64'd0);
      model_reset();
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      step({4{16'h0600}}, {4{16'h0800}}, '0, 1'b1, 1'b1, 1'b1, 1'b1, acc);
      idle(1'b1);
      chk("t6_after_valid", {63'b0, out_valid}, 64'd1);
      chk("t6_after_data", out_data, {4{16'h0C00}});
      drain("t6");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
